uart_tx_arbiter: RTL

Message-level round-robin arbiter and sequencer that shares the single uart_tx instance between NUM_REQ requesters, for example the state-machine status printer and the RX echo path.
- Each requester presents a fixed-width message buffer plus a byte length.
- The arbiter grants one requester, latches its message, and streams it byte by byte into uart_tx over the tx_data/tx_data_valid/tx_data_ready handshake.
- It pulses ack to the requester once the last byte has been accepted.
- It sits between the message sources and uart_tx, replacing the direct uart_controller-to-uart_tx connection.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Contents:
//   state_t          - arbiter sequencer states (IDLE, SEND, DONE, GAP)
//   CR_BYTE, LF_BYTE - line terminator bytes used by message sources
//   clog2()          - ceiling log2, used for index widths
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [7:0] CR_BYTE = 8'h0D;
  localparam logic [7:0] LF_BYTE = 8'h0A;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational circular priority select.
// The search starts at index ptr and wraps; the first set request wins.
// Ports:
//   req         in  NUM_REQ  request vector
//   ptr         in  ID_W     highest-priority index for this search
//   grant       out NUM_REQ  one-hot winner (all zero when nothing requested)
//   grant_idx   out ID_W     index of the winner
//   grant_valid out 1        at least one request was set
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_valid
);

  int pos;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    pos         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = (int'(ptr) + k) % NUM_REQ;
      if (!grant_valid && req[ID_W'(pos)]) begin
        grant_valid          = 1'b1;
        grant[ID_W'(pos)]    = 1'b1;
        grant_idx            = ID_W'(pos);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin arbiter and sequencer in front of uart_tx.
// A granted requester's message is copied into a local buffer, then streamed
// byte by byte (byte 0 = most significant byte of the slice) over a
// valid/ready handshake.
//
// Handshake: a byte transfers on every sys_clk edge where
// tx_data_valid && tx_data_ready; while valid is high and ready is low,
// tx_data and tx_data_valid hold their values.
//
// Ports:
//   sys_clk, sys_rst  clock, synchronous active-high reset
//   req               per-requester level request, held until ack
//   req_len           per-requester byte count (LEN_W each)
//   req_data          per-requester message (MSG_BYTES*8 each)
//   ack               one-cycle one-hot completion pulse
//   busy              high whenever the sequencer is not IDLE
//   grant_id          current or last granted requester
//   tx_data, tx_data_valid, tx_data_ready  byte stream to uart_tx
//   dbg_state         sequencer state for observation
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int MSG_BYTES = 21,
  parameter int LEN_W     = 5,
  localparam int ID_W     = clog2(NUM_REQ)
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*LEN_W-1:0]       req_len,
  input  logic [NUM_REQ*MSG_BYTES*8-1:0] req_data,
  output logic [NUM_REQ-1:0]             ack,
  output logic                           busy,
  output logic [ID_W-1:0]                grant_id,
  output logic [7:0]                     tx_data,
  output logic                           tx_data_valid,
  input  logic                           tx_data_ready,
  output logic [1:0]                     dbg_state
);

  localparam int MSG_W = MSG_BYTES * 8;

  state_t               state, next_state;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      arb_idx;
  logic [NUM_REQ-1:0]   arb_grant;
  logic                 arb_valid;
  logic [NUM_REQ-1:0]   grant_oh;
  logic [MSG_W-1:0]     msg_buf;
  logic [MSG_W-1:0]     sel_data;
  logic [LEN_W-1:0]     sel_len;
  logic [LEN_W-1:0]     eff_len;
  logic [LEN_W-1:0]     msg_len;
  logic [LEN_W-1:0]     idx;
  logic                 accept;
  logic                 last_byte;

  function automatic logic [7:0] byte_at(input logic [MSG_W-1:0] m,
                                         input logic [LEN_W-1:0] k);
    return m[(MSG_BYTES - 1 - int'(k)) * 8 +: 8];
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req         (req),
    .ptr         (rr_ptr),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  assign sel_data  = req_data[int'(arb_idx) * MSG_W +: MSG_W];
  assign sel_len   = req_len[int'(arb_idx) * LEN_W +: LEN_W];
  // Overlong requests are clipped to the buffer size, so idx stays in range.
  assign eff_len   = (sel_len > LEN_W'(MSG_BYTES)) ? LEN_W'(MSG_BYTES) : sel_len;
  assign accept    = tx_data_valid && tx_data_ready;
  assign last_byte = (idx == msg_len - LEN_W'(1));

  assign busy      = (state != IDLE);
  assign ack       = (state == DONE) ? grant_oh : '0;
  assign dbg_state = state;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (arb_valid) next_state = (eff_len == '0) ? DONE : SEND;
      SEND: if (accept && last_byte) next_state = DONE;
      DONE: next_state = GAP;
      // GAP gives a registered requester a cycle to drop req after ack.
      GAP:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rr_ptr        <= '0;
      grant_id      <= '0;
      grant_oh      <= '0;
      msg_buf       <= '0;
      msg_len       <= '0;
      idx           <= '0;
      tx_data       <= '0;
      tx_data_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant_id <= arb_idx;
            grant_oh <= arb_grant;
            rr_ptr   <= (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
            msg_buf  <= sel_data;
            msg_len  <= eff_len;
            idx      <= '0;
            if (eff_len != '0) begin
              tx_data       <= sel_data[MSG_W-1 -: 8];
              tx_data_valid <= 1'b1;
            end
          end
        end
        SEND: begin
          if (accept) begin
            if (last_byte) begin
              tx_data_valid <= 1'b0;
            end else begin
              idx     <= idx + LEN_W'(1);
              tx_data <= byte_at(msg_buf, idx + LEN_W'(1));
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
